// File: rtl/booth_pkg.sv
// Shared widths, FSM state type and Booth digit decode for the radix-4 sequential multiplier.
package booth_pkg;

    localparam int OPW   = 16;
    localparam int PPW   = 17;
    localparam int PW    = 32;
    localparam int NITER = 8;
    localparam int CNTW  = $clog2(NITER);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic neg;
        logic one;
        logic two;
    } booth_sel_t;

    function automatic booth_sel_t booth_decode(input logic [2:0] triple);
        booth_sel_t s;
        s = '0;
        case (triple)
            3'b001, 3'b010: s.one = 1'b1;
            3'b011:         s.two = 1'b1;
            3'b100: begin
                s.two = 1'b1;
                s.neg = 1'b1;
            end
            3'b101, 3'b110: begin
                s.one = 1'b1;
                s.neg = 1'b1;
            end
            default:        s = '0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/booth_pp_gen.sv
// Radix-4 Booth encoder and partial-product generator: one triple of the
// multiplier selects 0, +-A or +-2A of the 16-bit multiplicand.
module booth_pp_gen
    import booth_pkg::*;
(
    input  logic [2:0]     triple_i,
    input  logic [OPW-1:0] a_i,
    output logic [PPW-1:0] pp_o,
    output logic           pp_sign_o
);

    booth_sel_t     sel;
    logic [PPW-1:0] a_ext;
    logic [PPW-1:0] mag;

    always_comb begin
        sel   = booth_decode(triple_i);
        a_ext = {a_i[OPW-1], a_i};
        mag   = '0;
        if (sel.one) begin
            mag = a_ext;
        end else if (sel.two) begin
            mag = a_ext << 1;
        end
        pp_o = sel.neg ? (~mag + 1'b1) : mag;
        // -2 * -32768 = +65536 wraps in 17 bits; the true sign is carried
        // separately so the caller can sign-extend the exact value.
        pp_sign_o = (sel.one | sel.two) & (a_i != '0) & (sel.neg ^ a_i[OPW-1]);
    end

endmodule

// File: rtl/booth_seq_acc.sv
// Sequential radix-4 Booth multiplier, 16x16 -> 32 signed, one digit per cycle.
// Optional BOOTH_ZERO_SKIP_EN: zero operands bypass BUSY and finish immediately.
module booth_seq_acc
    import booth_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [OPW-1:0] a,
    input  logic [OPW-1:0] b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [PW-1:0]  p,
    output logic           busy
);

    state_t          state_q;
    logic [OPW-1:0]  a_q;
    logic [OPW-1:0]  b_q;
    logic [PW-1:0]   acc_q;
    logic [PW-1:0]   acc_d;
    logic [CNTW-1:0] cnt_q;
    logic [PW-1:0]   p_q;
    logic            in_ready_q;
    logic            out_valid_q;
    logic            busy_q;

    logic [OPW:0]    b_ext;
    logic [2:0]      triple;
    logic [PPW-1:0]  pp;
    logic            pp_sign;
    logic [PW-1:0]   pp_ext;
    logic [CNTW:0]   shamt;

    always_comb begin
        b_ext  = {b_q, 1'b0};
        triple = '0;
        for (int i = 0; i < NITER; i++) begin
            if (cnt_q == CNTW'(i)) begin
                triple = b_ext[2*i +: 3];
            end
        end
    end

    booth_pp_gen u_pp_gen (
        .triple_i  (triple),
        .a_i       (a_q),
        .pp_o      (pp),
        .pp_sign_o (pp_sign)
    );

    always_comb begin
        shamt  = {cnt_q, 1'b0};
        pp_ext = {{(PW-PPW){pp_sign}}, pp};
        acc_d  = acc_q + (pp_ext << shamt);
    end

    // State    | meaning
    // IDLE     | waiting for an operand pair, in_ready high
    // BUSY     | one Booth digit accumulated per cycle, NITER cycles
    // DONE     | product held on p until the consumer takes it
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            p_q         <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    in_ready_q <= 1'b1;
                    if (in_valid && in_ready_q) begin
                        a_q        <= a;
                        b_q        <= b;
                        acc_q      <= '0;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
`ifdef BOOTH_ZERO_SKIP_EN
                        if ((a == '0) || (b == '0)) begin
                            p_q         <= '0;
                            out_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end else begin
                            busy_q  <= 1'b1;
                            state_q <= BUSY;
                        end
`else
                        busy_q  <= 1'b1;
                        state_q <= BUSY;
`endif
                    end
                end
                BUSY: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNTW'(NITER - 1)) begin
                        p_q         <= acc_d;
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    in_ready_q  <= 1'b0;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign p         = p_q;

endmodule
